// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl
// Sequences an external up/down counter through repeated sweeps between two
// bounds: clear, count up to hi, dwell, count down to lo, dwell, repeat.
// The bounds are latched when a start is accepted.
//
// Optional feature macro: SWEEP_LIMIT_EN
//   defined   - run ends after NSWEEP sweeps via FINISH (done pulse) and the
//               sweeps output reports the number of completed sweeps.
//   undefined - run continues until stop; done is held 0; no sweeps port.
//
// Ports
//   clk    in   clock, rising edge
//   rs     in   asynchronous active-low reset
//   tick   in   count strobe; counter steps when tick && ss
//   start  in   one-cycle run request (ignored while busy)
//   stop   in   abort request, highest priority
//   lo/hi  in   sweep bounds (lo < hi required)
//   q      in   current count fed back from the counter
//   ss     out  counter enable
//   ud     out  counter direction (1 = up)
//   clr    out  synchronous clear to the counter
//   busy   out  high outside IDLE
//   done   out  one-cycle pulse on normal completion
//   err    out  one-cycle pulse on a rejected start
//   sweeps out  completed sweeps (SWEEP_LIMIT_EN only)
module counter_sweep_ctrl #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DWELL  = 4,
    parameter int unsigned NSWEEP = 3
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] q,
    output logic             ss,
    output logic             ud,
    output logic             clr,
    output logic             busy,
    output logic             done,
`ifdef SWEEP_LIMIT_EN
    output logic [7:0]       sweeps,
`endif
    output logic             err
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StUp,
        StDwellHi,
        StDown,
        StDwellLo,
        StFinish
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [7:0]       dwell_q;
    logic             err_q;
    logic             dwell_last;
`ifdef SWEEP_LIMIT_EN
    logic [7:0]       sweep_q;
`endif

    // Final tick of a dwell period.
    assign dwell_last = tick && (dwell_q == 8'(DWELL - 1));

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            state_q <= StIdle;
            lo_q    <= '0;
            hi_q    <= '0;
            dwell_q <= '0;
            err_q   <= 1'b0;
`ifdef SWEEP_LIMIT_EN
            sweep_q <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            // stop wins over everything, including a start seen in IDLE.
            if (stop) begin
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            if (lo < hi) begin
                                lo_q    <= lo;
                                hi_q    <= hi;
                                dwell_q <= '0;
`ifdef SWEEP_LIMIT_EN
                                sweep_q <= '0;
`endif
                                state_q <= StClear;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    StClear: state_q <= StUp;
                    StUp: begin
                        if (q == hi_q) state_q <= StDwellHi;
                    end
                    StDwellHi: begin
                        if (dwell_last) begin
                            dwell_q <= '0;
                            state_q <= StDown;
                        end else if (tick) begin
                            dwell_q <= dwell_q + 8'd1;
                        end
                    end
                    StDown: begin
                        if (q == lo_q) state_q <= StDwellLo;
                    end
                    StDwellLo: begin
                        if (dwell_last) begin
                            dwell_q <= '0;
`ifdef SWEEP_LIMIT_EN
                            sweep_q <= sweep_q + 8'd1;
                            if (sweep_q == 8'(NSWEEP - 1)) state_q <= StFinish;
                            else                           state_q <= StUp;
`else
                            state_q <= StUp;
`endif
                        end else if (tick) begin
                            dwell_q <= dwell_q + 8'd1;
                        end
                    end
                    StFinish: state_q <= StIdle;
                    default:  state_q <= StIdle;
                endcase
            end
        end
    end

    // Enable is combinational on q so the counter stops exactly at the bound.
    // It is also gated by stop so an abort freezes q in the cycle it is seen.
    always_comb begin
        ss = 1'b0;
        if (!stop) begin
            if (state_q == StUp)   ss = (q != hi_q);
            if (state_q == StDown) ss = (q != lo_q);
        end
    end

    assign ud   = (state_q != StDown);
    assign clr  = (state_q == StClear);
    assign busy = (state_q != StIdle);
    assign err  = err_q;
`ifdef SWEEP_LIMIT_EN
    assign done   = (state_q == StFinish);
    assign sweeps = sweep_q;
`else
    assign done = 1'b0;
`endif

endmodule
